// File: rtl/dshot_rx_decoder.sv
// dshot_rx_decoder
// Receive-side DSHOT150 decoder. Samples an asynchronous DSHOT line, measures
// each bit's high time, assembles a 16-bit frame MSB first, checks the 4-bit
// CRC and reports throttle/telemetry with single-cycle status strobes.
//
// Ports
//   i_sys_clk    : system clock (72 MHz)
//   i_rst_n      : asynchronous active-low reset
//   i_dshot      : DSHOT line, asynchronous to i_sys_clk
//   o_valid      : one-cycle strobe, good-CRC frame decoded
//   o_throttle   : frame bits [15:5] of the last good frame
//   o_telem      : frame bit [4] of the last good frame
//   o_crc_err    : one-cycle strobe, 16 bits received with bad CRC
//   o_frame_err  : one-cycle strobe, timing violation or incomplete frame
//   o_frame_cnt  : good-frame count, wraps
//   o_err_cnt    : CRC + framing error count, saturates
module dshot_rx_decoder #(
   parameter int unsigned BIT_THRESH_CYC  = 270,
   parameter int unsigned MIN_HIGH_CYC    = 90,
   parameter int unsigned MAX_HIGH_CYC    = 450,
   parameter int unsigned GAP_TIMEOUT_CYC = 720
) (
   input  logic        i_sys_clk,
   input  logic        i_rst_n,
   input  logic        i_dshot,
   output logic        o_valid,
   output logic [10:0] o_throttle,
   output logic        o_telem,
   output logic        o_crc_err,
   output logic        o_frame_err,
   output logic [15:0] o_frame_cnt,
   output logic [15:0] o_err_cnt
);

   localparam int unsigned HCNT_W  = 9;
   localparam int unsigned LCNT_W  = 10;
   localparam int unsigned IDX_W   = 5;
   localparam int unsigned FRAME_W = 16;

   localparam logic [HCNT_W-1:0] LP_THRESH = HCNT_W'(BIT_THRESH_CYC);
   localparam logic [HCNT_W-1:0] LP_MIN    = HCNT_W'(MIN_HIGH_CYC);
   localparam logic [HCNT_W-1:0] LP_MAX    = HCNT_W'(MAX_HIGH_CYC);
   localparam logic [LCNT_W-1:0] LP_GAP    = LCNT_W'(GAP_TIMEOUT_CYC);
   localparam logic [IDX_W-1:0]  LP_LAST   = IDX_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_HIGH,
      S_LOW,
      S_CHECK
   } state_t;

   // Synchronizer, registered edge detect and post-reset priming
   logic              r_sync1;
   logic              r_sync2;
   logic              r_prev;
   logic              r_rise;
   logic              r_fall;
   logic [1:0]        r_prime;

   state_t            r_state;
   logic [HCNT_W-1:0] r_hcnt;
   logic [LCNT_W-1:0] r_lcnt;
   logic [IDX_W-1:0]  r_idx;
   logic [FRAME_W-1:0] r_shift;

   logic              r_valid;
   logic              r_crc_err;
   logic              r_frame_err;
   logic [10:0]       r_throttle;
   logic              r_telem;
   logic [15:0]       r_frame_cnt;
   logic [15:0]       r_err_cnt;

   state_t            w_state_nxt;
   logic [HCNT_W-1:0] w_hcnt_nxt;
   logic [LCNT_W-1:0] w_lcnt_nxt;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [FRAME_W-1:0] w_shift_nxt;
   logic              w_valid_nxt;
   logic              w_crc_err_nxt;
   logic              w_frame_err_nxt;
   logic              w_primed;
   logic [11:0]       w_crc_v;
   logic [3:0]        w_crc_exp;

   // Edge flags lag r_sync2 by one cycle; priming keeps the FSM from acting on
   // the synchronizer's reset value as if it were a real low level.
   assign w_primed  = (r_prime == 2'b11);
   assign w_crc_v   = r_shift[15:4];
   assign w_crc_exp = w_crc_v[3:0] ^ w_crc_v[7:4] ^ w_crc_v[11:8];

   // Input synchronizer and edge detection
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_prime <= 2'b00;
      end else begin
         r_sync1 <= i_dshot;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_rise  <= r_sync2 & ~r_prev;
         r_fall  <= ~r_sync2 & r_prev;
         if (!w_primed) begin
            r_prime <= r_prime + 2'd1;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_WAIT_IDLE;
         r_hcnt  <= '0;
         r_lcnt  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hcnt  <= w_hcnt_nxt;
         r_lcnt  <= w_lcnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // Next-state, datapath and strobe decode
   always_comb begin
      w_state_nxt     = r_state;
      w_hcnt_nxt      = r_hcnt;
      w_lcnt_nxt      = r_lcnt;
      w_idx_nxt       = r_idx;
      w_shift_nxt     = r_shift;
      w_valid_nxt     = 1'b0;
      w_crc_err_nxt   = 1'b0;
      w_frame_err_nxt = 1'b0;
      unique case (r_state)
         S_WAIT_IDLE: begin
            if (w_primed && !r_sync2) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (r_rise) begin
               w_idx_nxt   = '0;
               w_hcnt_nxt  = '0;
               w_state_nxt = S_HIGH;
            end
         end
         S_HIGH: begin
            if (r_fall) begin
               if (r_hcnt < LP_MIN) begin
                  w_frame_err_nxt = 1'b1;
                  w_state_nxt     = S_WAIT_IDLE;
               end else begin
                  w_shift_nxt = {r_shift[FRAME_W-2:0], (r_hcnt > LP_THRESH)};
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  if (r_idx == LP_LAST) begin
                     w_state_nxt = S_CHECK;
                  end else begin
                     w_lcnt_nxt  = '0;
                     w_state_nxt = S_LOW;
                  end
               end
            end else if (r_hcnt > LP_MAX) begin
               w_frame_err_nxt = 1'b1;
               w_state_nxt     = S_WAIT_IDLE;
            end else if (r_hcnt != '1) begin
               w_hcnt_nxt = r_hcnt + HCNT_W'(1);
            end
         end
         S_LOW: begin
            if (r_rise) begin
               w_hcnt_nxt  = '0;
               w_state_nxt = S_HIGH;
            end else if (r_lcnt >= LP_GAP) begin
               // The increment that would take the count past the limit
               w_frame_err_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end else begin
               w_lcnt_nxt = r_lcnt + LCNT_W'(1);
            end
         end
         S_CHECK: begin
            if (w_crc_exp == r_shift[3:0]) begin
               w_valid_nxt = 1'b1;
            end else begin
               w_crc_err_nxt = 1'b1;
            end
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_WAIT_IDLE;
         end
      endcase
   end

   // Registered outputs and counters
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid     <= 1'b0;
         r_crc_err   <= 1'b0;
         r_frame_err <= 1'b0;
         r_throttle  <= '0;
         r_telem     <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_valid     <= w_valid_nxt;
         r_crc_err   <= w_crc_err_nxt;
         r_frame_err <= w_frame_err_nxt;
         if (w_valid_nxt) begin
            r_throttle  <= r_shift[15:5];
            r_telem     <= r_shift[4];
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if ((w_crc_err_nxt || w_frame_err_nxt) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign o_valid     = r_valid;
   assign o_crc_err   = r_crc_err;
   assign o_frame_err = r_frame_err;
   assign o_throttle  = r_throttle;
   assign o_telem     = r_telem;
   assign o_frame_cnt = r_frame_cnt;
   assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dshot_rx_decoder.sv
`timescale 1ns/1ps
module tb_dshot_rx_decoder;

   localparam int BIT_CYC = 480;
   localparam int GAP20US = 1440;
   localparam int GAP_S   = 300;
   localparam int K_VALID = 1;
   localparam int K_CRC   = 2;
   localparam int K_FERR  = 3;

   typedef struct {
      int          kind;
      int          lo;
      int          hi;
      logic [10:0] thr;
      logic        tel;
      logic [15:0] fcnt;
      logic [15:0] ecnt;
   } ev_t;

   typedef struct {
      logic [10:0] thr;
      logic        tel;
      logic [15:0] fcnt;
      logic [15:0] ecnt;
      bit          end_chk;
   } dir_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dshot;
   logic        o_valid;
   logic [10:0] o_throttle;
   logic        o_telem;
   logic        o_crc_err;
   logic        o_frame_err;
   logic [15:0] o_frame_cnt;
   logic [15:0] o_err_cnt;

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   ev_t  sb_q[$];
   dir_t dir_exp;
   int   dir_req  = 0;
   int   dir_seen = 0;

   dshot_rx_decoder dut (
      .i_sys_clk  (clk),
      .i_rst_n    (rst_n),
      .i_dshot    (dshot),
      .o_valid    (o_valid),
      .o_throttle (o_throttle),
      .o_telem    (o_telem),
      .o_crc_err  (o_crc_err),
      .o_frame_err(o_frame_err),
      .o_frame_cnt(o_frame_cnt),
      .o_err_cnt  (o_err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Compare helper, used only by the monitor process
   task automatic cmp(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every strobe, serves direct snapshot checks
   always @(negedge clk) begin
      int  nstb;
      int  act_kind;
      ev_t e;
      if (dir_req != dir_seen) begin
         dir_seen = dir_req;
         if (dir_exp.end_chk) begin
            cmp("pending_events", sb_q.size(), 0);
         end else begin
            cmp("snap_throttle", int'(o_throttle), int'(dir_exp.thr));
            cmp("snap_telem", int'(o_telem), int'(dir_exp.tel));
            cmp("snap_frame_cnt", int'(o_frame_cnt), int'(dir_exp.fcnt));
            cmp("snap_err_cnt", int'(o_err_cnt), int'(dir_exp.ecnt));
            cmp("snap_strobes", int'({o_valid, o_crc_err, o_frame_err}), 0);
         end
      end
      nstb = int'(o_valid) + int'(o_crc_err) + int'(o_frame_err);
      if (rst_n === 1'b1) begin
         if (nstb != 0) begin
            cmp("strobe_exclusive", int'(nstb > 1), 0);
            act_kind = o_valid ? K_VALID : (o_crc_err ? K_CRC : K_FERR);
            if (sb_q.size() == 0) begin
               cmp("unexpected_strobe_kind", act_kind, 0);
            end else begin
               e = sb_q.pop_front();
               cmp("strobe_kind", act_kind, e.kind);
               total++;
               if (cyc < e.lo || cyc > e.hi) begin
                  bad++;
                  $display("FAIL strobe_cycle: got %0d expected %0d..%0d", cyc, e.lo, e.hi);
               end
               cmp("throttle", int'(o_throttle), int'(e.thr));
               cmp("telem", int'(o_telem), int'(e.tel));
               cmp("frame_cnt", int'(o_frame_cnt), int'(e.fcnt));
               cmp("err_cnt", int'(o_err_cnt), int'(e.ecnt));
            end
         end else if (sb_q.size() != 0 && cyc > sb_q[0].hi) begin
            e = sb_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_strobe: kind %0d not seen by cycle %0d (now %0d)", e.kind, e.hi, cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic direct(input dir_t d);
      dir_exp = d;
      dir_req++;
      tick(2);
   endtask

   function automatic ev_t mk(input int kind, input int thr, input int tel,
                              input int fcnt, input int ecnt);
      ev_t e;
      e.kind = kind;
      e.lo   = 0;
      e.hi   = 0;
      e.thr  = 11'(thr);
      e.tel  = 1'(tel);
      e.fcnt = 16'(fcnt);
      e.ecnt = 16'(ecnt);
      return e;
   endfunction

   function automatic dir_t snap(input int thr, input int tel, input int fcnt,
                                 input int ecnt, input bit end_chk);
      dir_t d;
      d.thr     = 11'(thr);
      d.tel     = 1'(tel);
      d.fcnt    = 16'(fcnt);
      d.ecnt    = 16'(ecnt);
      d.end_chk = end_chk;
      return d;
   endfunction

   // Drives nbits of frame f (bit 1 = MSB). Bit ov_idx uses ov_high instead of
   // its nominal high time. The falling edge of bit ev_bit schedules ev in the
   // window [fall+off_lo, fall+off_hi], in monitor cycle numbering.
   task automatic send_frame(input logic [15:0] f, input int nbits,
                             input int ov_idx, input int ov_high, input int tail_low,
                             input int ev_bit, input int off_lo, input int off_hi,
                             input ev_t ev);
      int  high;
      ev_t e;
      for (int k = 1; k <= nbits; k++) begin
         high = (((f >> (16 - k)) & 16'h1) != 16'h0) ? 360 : 180;
         if (k == ov_idx) high = ov_high;
         dshot = 1'b1;
         tick(high);
         dshot = 1'b0;
         if (k == ev_bit) begin
            e    = ev;
            e.lo = cyc + off_lo;
            e.hi = cyc + off_hi;
            sb_q.push_back(e);
         end
         tick((k < nbits) ? (BIT_CYC - high) : tail_low);
      end
   endtask

   task automatic good(input logic [15:0] f, input int thr, input int tel,
                       input int fcnt, input int ecnt, input int tail);
      send_frame(f, 16, 0, 0, tail, 16, 5, 5, mk(K_VALID, thr, tel, fcnt, ecnt));
   endtask

   initial begin
      rst_n = 1'b0;
      dshot = 1'b0;
      tick(5);
      direct(snap(0, 0, 0, 0, 1'b0));
      rst_n = 1'b1;
      tick(10);

      // Good frame, telemetry off
      good(16'h0606, 48, 0, 1, 0, GAP_S);
      // Back-to-back, 20 us apart
      good(16'h82D7, 1046, 1, 2, 0, GAP20US);
      good(16'h0606, 48, 0, 3, 0, GAP_S);
      // Bad CRC, next frame starts 2 cycles after its last fall
      send_frame(16'h0607, 16, 0, 0, 2, 16, 5, 5, mk(K_CRC, 48, 0, 3, 1));
      // Bit 5 glitch of 60 cycles, frame abandoned
      send_frame(16'h0606, 5, 5, 60, GAP_S, 5, 4, 4, mk(K_FERR, 48, 0, 3, 2));
      // Good frame with a '0' bit held high 270 cycles
      send_frame(16'h0606, 16, 1, 270, GAP_S, 16, 5, 5, mk(K_VALID, 48, 0, 4, 2));
      // Stall low 800 cycles after bit 9
      send_frame(16'h0606, 9, 0, 0, 800, 9, 721, 725, mk(K_FERR, 48, 0, 4, 3));
      // Good frame with a '1' bit held high only 272 cycles
      send_frame(16'h82D7, 16, 1, 272, GAP_S, 16, 5, 5, mk(K_VALID, 1046, 1, 5, 3));

      // Reset during bit 8
      send_frame(16'h0606, 7, 0, 0, 300, 0, 0, 0, mk(0, 0, 0, 0, 0));
      dshot = 1'b1;
      tick(50);
      rst_n = 1'b0;
      #1;
      direct(snap(0, 0, 0, 0, 1'b0));
      tick(8);
      rst_n = 1'b1;
      tick(100);
      dshot = 1'b0;
      tick(GAP_S);
      good(16'h0606, 48, 0, 1, 0, GAP_S);

      tick(20);
      direct(snap(0, 0, 0, 0, 1'b1));
      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
